pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Program-counter and fetch sequencer for the single-cycle CPU. It owns the PC register and drives the instruction ROM word address. It computes next-PC from control and decode inputs (sequential, beq/bne, j/jal, jr) and gates PC advance through a run/halt/single-step FSM for bring-up. It also exposes the link address for jal, a retire pulse and a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous active-high reset.
run_en  in  1  level; 1 = free-run, 0 = halt after the current commit.
step_req  in  1  single-cycle pulse; requests one commit while halted.
br_taken  in  1  branch condition resolved true (beq/bne) this cycle.
br_off  in  16  raw branch immediate.
jmp  in  1  j/jal this cycle.
jmp_idx  in  26  raw jump index field.
jr  in  1  jr this cycle.
jr_tgt  in  32  register value for jr.
inst_addr  out  32  byte address to instruction ROM; equals pc.
pc_plus4  out  32  pc+4; link value for jal.
commit  out  1  1 when the instruction at pc retires this cycle.
halted  out  1  1 in HALT state.
misalign  out  1  sticky; jr target had nonzero low 2 bits.
retire_cnt  out  CNT_W  number of committed instructions.

Behaviour:
- Reset (async, any time, including mid-step): pc=RESET_PC, state=BOOT, misalign=0, retire_cnt=0, commit=0, halted=0. Deassertion is synchronised by the clk edge only; no reset synchroniser inside.
- FSM states: BOOT, RUN, HALT, STEP.
  - BOOT: lasts exactly one cycle, commit=0. Next state is RUN if run_en, else HALT.
  - RUN: commit=run_en. If run_en=0, go to HALT with no commit that cycle.
  - HALT: commit=0, halted=1. step_req=1 goes to STEP. run_en=1 goes to RUN. If both are 1, run_en wins.
  - STEP: commit=1 for exactly one cycle, then HALT, regardless of step_req. step_req is ignored outside HALT.
- On commit: pc <= next_pc and retire_cnt <= retire_cnt+1 (wraps modulo 2^CNT_W). Without commit, pc and retire_cnt hold.
- next_pc priority: jr > jmp > br_taken > sequential.
  - seq: pc+4.
  - branch: pc+4 + (sign_extend(br_off) << 2), modulo 2^32.
  - jump: {pc_plus4[31:28], jmp_idx, 2'b00}.
  - jr: {jr_tgt[31:2], 2'b00}. If jr_tgt[1:0]!=0 and commit, misalign <= 1 (sticky until rst).
- Control inputs sampled only in commit cycles; simultaneous jr/jmp/br_taken resolved by the priority above, with no error flag.
- Arithmetic on pc is 32-bit unsigned with wrap (0xFFFF_FFFC+4 = 0). pc[1:0] is always 00.
- inst_addr and pc_plus4 are combinational from pc; all other outputs are registered or purely state-decoded. No combinational path from inputs to commit except run_en in RUN.
- Latency: a change of control inputs affects pc on the next rising edge after a commit cycle.

Decomposition:
- Shared package/header: FSM state encodings (BOOT=2'd0, RUN=2'd1, HALT=2'd2, STEP=2'd3), RESET_PC default, opcode-independent constants (word shift 2).
- One natural sub-module: next_pc_calc (pure combinational: pc, br/jmp/jr inputs -> next_pc, misalign_now).
- FSM, PC register and counter stay in pc_fetch_ctrl.

Test Plan:
- Reset, run_en=1, no control -> cycle after BOOT: inst_addr 0x0, then 0x4, 0x8; retire_cnt counts 1,2,3; commit low during BOOT.
- At pc=0x0 assert jmp, jmp_idx=0x5 -> next inst_addr 0x14; at pc=0x30 jmp with jmp_idx=0x2 -> pc_plus4=0x34 during that cycle, next inst_addr 0x08.
- At pc=0x40, br_taken=1, br_off=0xFFEE -> next pc 0xFFFF_FFFC; then with no control, next pc 0x0000_0000 (wrap).
- At pc=0x10 assert jr=1, jr_tgt=0x35, jmp=1, br_taken=1 simultaneously -> next pc 0x34, misalign=1 and stays 1 until rst.
- run_en=0 -> halted=1, pc frozen. A step_req pulse -> exactly one commit, pc +4, back to HALT. A 3-cycle-wide step_req -> still exactly one commit. Assert rst during STEP -> pc=RESET_PC, retire_cnt=0 immediately (async).

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the PC / fetch sequencer.
package pc_fetch_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_SHIFT = 2;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } state_e;

endpackage

// File: rtl/pc_fetch_ctrl_next_pc_calc.sv
// Pure combinational next-PC selection: jr > jmp > branch > sequential.
module pc_fetch_ctrl_next_pc_calc
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            br_taken_i,
  input  logic [15:0]     br_off_i,
  input  logic            jmp_i,
  input  logic [25:0]     jmp_idx_i,
  input  logic            jr_i,
  input  logic [XLEN-1:0] jr_tgt_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misalign_now_o
);

  logic [XLEN-1:0] br_disp;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jmp_tgt;
  logic [XLEN-1:0] jr_word;

  assign pc_plus4_o = pc_i + XLEN'(4);
  assign br_disp    = {{16{br_off_i[15]}}, br_off_i} << WORD_SHIFT;
  assign br_tgt     = pc_plus4_o + br_disp;
  assign jmp_tgt    = {pc_plus4_o[31:28], jmp_idx_i, 2'b00};
  assign jr_word    = {jr_tgt_i[31:2], 2'b00};

  always_comb begin
    next_pc_o      = pc_plus4_o;
    misalign_now_o = 1'b0;
    if (jr_i) begin
      next_pc_o      = jr_word;
      misalign_now_o = (jr_tgt_i[1:0] != 2'b00);
    end else if (jmp_i) begin
      next_pc_o = jmp_tgt;
    end else if (br_taken_i) begin
      next_pc_o = br_tgt;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, run/halt/single-step fetch FSM and retired-instruction counter.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             step_req,
  input  logic             br_taken,
  input  logic [15:0]      br_off,
  input  logic             jmp,
  input  logic [25:0]      jmp_idx,
  input  logic             jr,
  input  logic [31:0]      jr_tgt,
  output logic [31:0]      inst_addr,
  output logic [31:0]      pc_plus4,
  output logic             commit,
  output logic             halted,
  output logic             misalign,
  output logic [CNT_W-1:0] retire_cnt
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misalign_q, misalign_d;
  logic             step_req_q;
  logic             step_rise;
  logic [31:0]      next_pc;
  logic             misalign_now;

  pc_fetch_ctrl_next_pc_calc u_next_pc (
    .pc_i           (pc_q),
    .br_taken_i     (br_taken),
    .br_off_i       (br_off),
    .jmp_i          (jmp),
    .jmp_idx_i      (jmp_idx),
    .jr_i           (jr),
    .jr_tgt_i       (jr_tgt),
    .pc_plus4_o     (pc_plus4),
    .next_pc_o      (next_pc),
    .misalign_now_o (misalign_now)
  );

  // A held step_req must yield one commit, so HALT reacts to its rising edge only.
  assign step_rise = step_req & ~step_req_q;

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = run_en ? ST_RUN : ST_HALT;
      ST_RUN: begin
        if (run_en) commit  = 1'b1;
        else        state_d = ST_HALT;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (run_en)         state_d = ST_RUN;
        else if (step_rise) state_d = ST_STEP;
      end
      ST_STEP: begin
        commit  = 1'b1;
        state_d = ST_HALT;
      end
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    misalign_d = misalign_q;
    if (commit) begin
      pc_d       = next_pc;
      cnt_d      = cnt_q + CNT_W'(1);
      misalign_d = misalign_q | misalign_now;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      step_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      step_req_q <= step_req;
    end
  end

  assign inst_addr  = pc_q;
  assign misalign   = misalign_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_en;
  logic        step_req;
  logic        br_taken;
  logic [15:0] br_off;
  logic        jmp;
  logic [25:0] jmp_idx;
  logic        jr;
  logic [31:0] jr_tgt;
  logic [31:0] inst_addr;
  logic [31:0] pc_plus4;
  logic        commit;
  logic        halted;
  logic        misalign;
  logic [31:0] retire_cnt;

  int checks   = 0;
  int failures = 0;

  pc_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .run_en     (run_en),
    .step_req   (step_req),
    .br_taken   (br_taken),
    .br_off     (br_off),
    .jmp        (jmp),
    .jmp_idx    (jmp_idx),
    .jr         (jr),
    .jr_tgt     (jr_tgt),
    .inst_addr  (inst_addr),
    .pc_plus4   (pc_plus4),
    .commit     (commit),
    .halted     (halted),
    .misalign   (misalign),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    step_req = 1'b0;
    br_taken = 1'b0;
    br_off   = 16'h0;
    jmp      = 1'b0;
    jmp_idx  = 26'h0;
    jr       = 1'b0;
    jr_tgt   = 32'h0;
  endtask

  // Leaves the DUT one edge past BOOT (RUN or HALT depending on run).
  task automatic do_reset(input logic run);
    clear_ctrl();
    run_en = run;
    rst    = 1'b1;
    step_clk();
    rst = 1'b0;
    step_clk();
  endtask

  task automatic test_reset();
    clear_ctrl();
    run_en = 1'b1;
    rst    = 1'b1;
    repeat (2) step_clk();
    checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", inst_addr, 32'h0); end
    checks++; if (retire_cnt !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=%h", retire_cnt, 32'h0); end
    checks++; if ({commit, halted, misalign} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {commit, halted, misalign}); end
    rst = 1'b0;
    #1;
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL boot_commit got=%b exp=0", commit); end
    step_clk();
    checks++; if (inst_addr !== 32'h0 || commit !== 1'b1) begin failures++; $display("FAIL run_first got=%h/%b exp=00000000/1", inst_addr, commit); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      step_clk();
      checks++;
      if (inst_addr !== 32'(4 * i) || retire_cnt !== 32'(i)) begin
        failures++;
        $display("FAIL seq_%0d got=%h/%0d exp=%h/%0d", i, inst_addr, retire_cnt, 32'(4 * i), i);
      end
    end
  endtask

  task automatic test_jump();
    do_reset(1'b1);
    jmp = 1'b1; jmp_idx = 26'h5;
    step_clk();
    checks++; if (inst_addr !== 32'h14) begin failures++; $display("FAIL jmp_5 got=%h exp=%h", inst_addr, 32'h14); end
    jmp_idx = 26'hC;
    step_clk();
    checks++; if (inst_addr !== 32'h30) begin failures++; $display("FAIL jmp_c got=%h exp=%h", inst_addr, 32'h30); end
    jmp_idx = 26'h2;
    #1;
    checks++; if (pc_plus4 !== 32'h34) begin failures++; $display("FAIL link got=%h exp=%h", pc_plus4, 32'h34); end
    step_clk();
    checks++; if (inst_addr !== 32'h08) begin failures++; $display("FAIL jmp_2 got=%h exp=%h", inst_addr, 32'h08); end
    clear_ctrl();
  endtask

  task automatic test_branch_wrap();
    jmp = 1'b1; jmp_idx = 26'h10;
    step_clk();
    clear_ctrl();
    br_taken = 1'b1; br_off = 16'hFFEE;
    step_clk();
    checks++; if (inst_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL br_back got=%h exp=%h", inst_addr, 32'hFFFF_FFFC); end
    checks++; if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL plus4_wrap got=%h exp=%h", pc_plus4, 32'h0); end
    clear_ctrl();
    step_clk();
    checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL seq_wrap got=%h exp=%h", inst_addr, 32'h0); end
    br_taken = 1'b1; br_off = 16'h0003;
    step_clk();
    checks++; if (inst_addr !== 32'h10) begin failures++; $display("FAIL br_fwd got=%h exp=%h", inst_addr, 32'h10); end
    clear_ctrl();
  endtask

  task automatic test_priority();
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL misalign_pre got=%b exp=0", misalign); end
    jr = 1'b1; jr_tgt = 32'h35; jmp = 1'b1; jmp_idx = 26'h7; br_taken = 1'b1; br_off = 16'h5;
    step_clk();
    checks++; if (inst_addr !== 32'h34) begin failures++; $display("FAIL jr_prio got=%h exp=%h", inst_addr, 32'h34); end
    checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL misalign_set got=%b exp=1", misalign); end
    clear_ctrl();
    step_clk();
    checks++; if (misalign !== 1'b1 || inst_addr !== 32'h38) begin failures++; $display("FAIL misalign_sticky got=%b/%h exp=1/00000038", misalign, inst_addr); end
  endtask

  task automatic test_halt_step();
    do_reset(1'b1);
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL misalign_clr got=%b exp=0", misalign); end
    step_clk();
    run_en = 1'b0;
    #1;
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL run_drop_commit got=%b exp=0", commit); end
    step_clk();
    step_clk();
    checks++; if (halted !== 1'b1 || inst_addr !== 32'h4 || retire_cnt !== 32'd1) begin failures++; $display("FAIL halt_frozen got=%b/%h/%0d exp=1/00000004/1", halted, inst_addr, retire_cnt); end
    step_req = 1'b1;
    step_clk();
    step_req = 1'b0;
    #1;
    checks++; if (commit !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL step_state got=%b/%b exp=1/0", commit, halted); end
    repeat (2) step_clk();
    checks++; if (inst_addr !== 32'h8 || retire_cnt !== 32'd2 || halted !== 1'b1) begin failures++; $display("FAIL step_one got=%h/%0d/%b exp=00000008/2/1", inst_addr, retire_cnt, halted); end
    step_req = 1'b1;
    repeat (3) step_clk();
    step_req = 1'b0;
    repeat (2) step_clk();
    checks++; if (inst_addr !== 32'hC || retire_cnt !== 32'd3) begin failures++; $display("FAIL step_wide got=%h/%0d exp=0000000c/3", inst_addr, retire_cnt); end
    step_req = 1'b1;
    step_clk();
    step_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (inst_addr !== 32'h0 || retire_cnt !== 32'd0 || commit !== 1'b0) begin failures++; $display("FAIL rst_in_step got=%h/%0d/%b exp=00000000/0/0", inst_addr, retire_cnt, commit); end
    step_clk();
    rst = 1'b0;
  endtask

  task automatic test_run_wins();
    do_reset(1'b0);
    checks++; if (halted !== 1'b1 || inst_addr !== 32'h0) begin failures++; $display("FAIL boot_to_halt got=%b/%h exp=1/00000000", halted, inst_addr); end
    run_en = 1'b1; step_req = 1'b1;
    step_clk();
    step_req = 1'b0;
    checks++; if (halted !== 1'b0 || commit !== 1'b1 || inst_addr !== 32'h0) begin failures++; $display("FAIL run_wins got=%b/%b/%h exp=0/1/00000000", halted, commit, inst_addr); end
    step_clk();
    checks++; if (inst_addr !== 32'h4 || retire_cnt !== 32'd1) begin failures++; $display("FAIL run_after got=%h/%0d exp=00000004/1", inst_addr, retire_cnt); end
  endtask

  initial begin
    rst    = 1'b1;
    run_en = 1'b0;
    clear_ctrl();
    test_reset();
    test_sequential();
    test_jump();
    test_branch_wrap();
    test_priority();
    test_halt_step();
    test_run_wins();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
